reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HoldCycles, default 16: cycles both resets stay asserted after any reset event (legal 2..65535).
REQ-002 SHALL have parameter StaggerCycles, default 8: cycles between peripheral release and core release (legal 1..65535).
REQ-003 SHALL have parameter DebounceCycles, default 1000: consecutive stable cycles needed to accept a button press (legal 1..2^20).
REQ-004 SHALL have port clk_sys_i, input, 1: system clock.
REQ-005 SHALL have port rst_sys_ni, input, 1: system reset, asynchronous, active-low; driven from the clock generator lock AND the board reset pin.
REQ-006 SHALL have port btn_rst_i, input, 1: user reset button, asynchronous, active-high.
REQ-007 SHALL have port ndmreset_i, input, 1: debug-module reset request, synchronous to clk_sys_i, level-sensitive.
REQ-008 SHALL have port sw_rst_req_i, input, 1: software reset request, synchronous single-cycle pulse.
REQ-009 SHALL have port rst_periph_no, output, 1: peripheral/bus reset, active-low, registered.
REQ-010 SHALL have port rst_core_no, output, 1: CPU core reset, active-low, registered.
REQ-011 SHALL have port rst_cause_o, output, 4: latched cause, bit0 POR, bit1 button, bit2 debug, bit3 software.
REQ-012 SHALL have port seq_busy_o, output, 1: high while not in ST_RUN.

Function
REQ-013 SHALL implement FSM ST_HOLD -> ST_STAGGER -> ST_RUN. One 16-bit counter is cleared on every state entry.
REQ-014 In ST_HOLD: rst_periph_no=0 and rst_core_no=0. After the counter reaches HoldCycles-1 with no active request, the FSM SHALL move to ST_STAGGER.
REQ-015 In ST_STAGGER: rst_periph_no=1 and rst_core_no=0. After the counter reaches StaggerCycles-1, the FSM SHALL move to ST_RUN.
REQ-016 In ST_RUN: both reset outputs=1, seq_busy_o=0.
REQ-017 In any state, an accepted request (button press, ndmreset_i high, sw_rst_req_i high) SHALL move the FSM to ST_HOLD with the counter cleared, so a request during ST_HOLD/ST_STAGGER restarts the full sequence.
REQ-018 Request-to-output latency SHALL be one clock: outputs low on the edge after the request is sampled.
REQ-019 While ndmreset_i stays high, the FSM SHALL remain in ST_HOLD with the counter held at 0. Release timing counts from the first cycle ndmreset_i is low.
REQ-020 btn_rst_i SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-021 The debouncer SHALL produce one request pulse when the synchronized level has been high for DebounceCycles consecutive cycles. It SHALL produce no further pulse until the level has been low for DebounceCycles consecutive cycles.
REQ-022 Glitches shorter than DebounceCycles SHALL produce no request. The debounce counter SHALL saturate and never wrap.
REQ-023 On each accepted request, rst_cause_o SHALL load the OR of all request sources active in that cycle. POR is never set by a request.
REQ-024 rst_cause_o SHALL hold its value until the next accepted request.

Reset
REQ-025 Asserting rst_sys_ni SHALL immediately and asynchronously force: state ST_HOLD, counter 0, rst_periph_no=0, rst_core_no=0, rst_cause_o=4'b0001, seq_busy_o=1, synchronizer flops 0, debouncer idle (counter 0, released).
REQ-026 Deassertion of rst_sys_ni mid-sequence SHALL begin a fresh ST_HOLD count. No partial state survives.
REQ-027 Every flop in the block SHALL use rst_sys_ni only. Generated outputs SHALL never reset the block itself.

Structure
REQ-028 A package reset_seq_pkg SHALL hold the state enum (ST_HOLD, ST_STAGGER, ST_RUN), the cause bit index constants, and the counter width constant.
REQ-029 The synchronizer and debouncer SHALL form one sub-module, reset_debounce, parameterised by DebounceCycles, outputting a single-cycle press pulse.

Verification (HoldCycles=16, StaggerCycles=8, DebounceCycles=4)
REQ-030 POR: release rst_sys_ni at edge 0 -> rst_periph_no rises at edge 16, rst_core_no at edge 24, rst_cause_o=0001, seq_busy_o falls at edge 24.
REQ-031 Software reset: sw_rst_req_i pulse in ST_RUN -> both resets low next edge, periph high 16 cycles later, core high 8 cycles after that, rst_cause_o=1000.
REQ-032 Button: btn_rst_i high for 3 cycles -> no reset. btn_rst_i high for 10 cycles -> exactly one sequence, rst_cause_o=0010, first reset edge 2+4+1 cycles after assertion.
REQ-033 Debug hold: ndmreset_i high for 50 cycles during ST_STAGGER -> rst_periph_no low within 1 cycle, stays low for 50+16 cycles, rst_cause_o=0100.
REQ-034 Simultaneous events: sw_rst_req_i and ndmreset_i in the same cycle -> rst_cause_o=1100. A second sw pulse at hold count 10 restarts the 16-cycle count.
REQ-035 Async reset mid-sequence: drop rst_sys_ni at stagger count 3 -> outputs low immediately without a clock edge, rst_cause_o=0001, full 16+8 sequence after release.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, cause bit
// positions and the sequencing counter width.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_BTN = 1;
    localparam int CAUSE_DBG = 2;
    localparam int CAUSE_SW  = 3;

    localparam int CNT_W = 16;

endpackage

// File: rtl/reset_debounce.sv
// Synchronises the asynchronous reset button and emits a single-cycle press
// pulse once the level has been stable high for DebounceCycles cycles.
module reset_debounce #(
    parameter int DebounceCycles = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DebounceCycles) + 1;
    localparam logic [CW-1:0] LAST = CW'(DebounceCycles - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed_q;
    logic [CW-1:0] cnt_q;

    // The counter only runs while the synchronised level disagrees with the
    // accepted state, so it is bounded by LAST and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            press     <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press   <= 1'b0;
            if (sync2_q == pressed_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q     <= '0;
                pressed_q <= sync2_q;
                press     <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds peripheral and core in reset, then releases
// the peripherals first and the core StaggerCycles later.
module reset_sequencer #(
    parameter int HoldCycles     = 16,
    parameter int StaggerCycles  = 8,
    parameter int DebounceCycles = 1000
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       btn_rst_i,
    input  logic       ndmreset_i,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic [3:0] rst_cause_o,
    output logic       seq_busy_o
);

    import reset_seq_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HoldCycles - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(StaggerCycles - 1);
    localparam logic [3:0]       POR_CAUSE    = 4'(1 << CAUSE_POR);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_press;
    logic             req;
    logic [3:0]       req_cause;

    reset_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_debounce (
        .clk  (clk_sys_i),
        .rst_n(rst_sys_ni),
        .btn  (btn_rst_i),
        .press(btn_press)
    );

    always_comb begin
        req_cause            = '0;
        req_cause[CAUSE_BTN] = btn_press;
        req_cause[CAUSE_DBG] = ndmreset_i;
        req_cause[CAUSE_SW]  = sw_rst_req_i;
    end

    assign req = |req_cause;

    // A request wins over every state, so a held ndmreset_i pins the counter at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_STAGGER;
                        cnt_d   = '0;
                    end
                end
                ST_STAGGER: begin
                    if (cnt_q == STAGGER_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            rst_periph_no <= 1'b0;
            rst_core_no   <= 1'b0;
            seq_busy_o    <= 1'b1;
            rst_cause_o   <= POR_CAUSE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_periph_no <= (state_d != ST_HOLD);
            rst_core_no   <= (state_d == ST_RUN);
            seq_busy_o    <= (state_d != ST_RUN);
            if (req) begin
                rst_cause_o <= req_cause;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: an event-based timing model checked every
// cycle, plus literal expectations at the interesting edges.
module tb_reset_sequencer;

    localparam int H = 16;
    localparam int S = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic       ndm = 1'b0;
    logic       sw = 1'b0;
    logic       rst_periph_n;
    logic       rst_core_n;
    logic [3:0] cause;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    reset_sequencer #(
        .HoldCycles    (H),
        .StaggerCycles (S),
        .DebounceCycles(D)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_ni   (rst_n),
        .btn_rst_i    (btn),
        .ndmreset_i   (ndm),
        .sw_rst_req_i (sw),
        .rst_periph_no(rst_periph_n),
        .rst_core_no  (rst_core_n),
        .rst_cause_o  (cause),
        .seq_busy_o   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: each reset event happens at an edge; periph releases H edges later,
    // core H+S edges later. The button is accepted when the last D synchronised
    // samples (button value two edges earlier) are all high.
    int       cyc = 0;
    int       last_req = 0;
    logic [3:0] m_cause = 4'b0001;
    bit       pressed = 1'b0;
    bit       m_pulse = 1'b0;
    bit       btnq[$];
    bit       synq[$];

    always @(posedge clk) begin
        bit req_btn;
        bit s;
        bit all_hi;
        bit all_lo;
        cyc++;
        if (!rst_n) begin
            last_req = cyc;
            m_cause  = 4'b0001;
            pressed  = 1'b0;
            m_pulse  = 1'b0;
            btnq.delete();
            synq.delete();
        end else begin
            req_btn = m_pulse;
            m_pulse = 1'b0;
            s = (btnq.size() == 2) ? btnq[0] : 1'b0;
            btnq.push_back(btn);
            if (btnq.size() > 2) btnq.delete(0);
            synq.push_back(s);
            if (synq.size() > D) synq.delete(0);
            if (synq.size() == D) begin
                all_hi = 1'b1;
                all_lo = 1'b1;
                foreach (synq[i]) begin
                    if (synq[i]) all_lo = 1'b0;
                    else all_hi = 1'b0;
                end
                if (!pressed && all_hi) begin
                    pressed = 1'b1;
                    m_pulse = 1'b1;
                end else if (pressed && all_lo) begin
                    pressed = 1'b0;
                end
            end
            if (sw || ndm || req_btn) begin
                last_req = cyc;
                m_cause  = {sw, ndm, req_btn, 1'b0};
            end
        end
    end

    always @(negedge clk) begin
        logic ep;
        logic ec;
        if (started) begin
            ep = rst_n && ((cyc - last_req) >= H);
            ec = rst_n && ((cyc - last_req) >= H + S);
            check("cmp_periph", rst_periph_n, ep);
            check("cmp_core", rst_core_n, ec);
            check("cmp_busy", busy, !ec);
            check("cmp_cause", cause, rst_n ? m_cause : 4'b0001);
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        started = 1'b1;
        #1;
        check("reset_periph", rst_periph_n, 0);
        check("reset_core", rst_core_n, 0);
        check("reset_cause", cause, 4'b0001);
        check("reset_busy", busy, 1);

        // Power-on release
        ticks(3);
        rst_n = 1'b1;
        ticks(15);
        check("por_periph_e15", rst_periph_n, 0);
        ticks(1);
        check("por_periph_e16", rst_periph_n, 1);
        check("por_core_e16", rst_core_n, 0);
        ticks(7);
        check("por_core_e23", rst_core_n, 0);
        ticks(1);
        check("por_core_e24", rst_core_n, 1);
        check("por_busy_e24", busy, 0);
        check("por_cause", cause, 4'b0001);

        // Software reset pulse from run
        ticks(4);
        sw = 1'b1;
        ticks(1);
        sw = 1'b0;
        check("sw_periph_low", rst_periph_n, 0);
        check("sw_core_low", rst_core_n, 0);
        check("sw_busy", busy, 1);
        check("sw_cause", cause, 4'b1000);
        ticks(15);
        check("sw_periph_h15", rst_periph_n, 0);
        ticks(1);
        check("sw_periph_h16", rst_periph_n, 1);
        ticks(7);
        check("sw_core_s7", rst_core_n, 0);
        ticks(1);
        check("sw_core_s8", rst_core_n, 1);

        // Button glitch, then a real press
        ticks(3);
        btn = 1'b1;
        ticks(3);
        btn = 1'b0;
        ticks(20);
        check("btn_glitch_core", rst_core_n, 1);
        check("btn_glitch_cause", cause, 4'b1000);
        btn = 1'b1;
        ticks(6);
        check("btn_before_accept", rst_periph_n, 1);
        ticks(1);
        check("btn_accept_periph", rst_periph_n, 0);
        check("btn_cause", cause, 4'b0010);
        ticks(3);
        btn = 1'b0;
        ticks(21);
        check("btn_core_release", rst_core_n, 1);
        ticks(30);
        check("btn_single_core", rst_core_n, 1);
        check("btn_single_cause", cause, 4'b0010);

        // Debug reset held for 50 cycles during stagger
        sw = 1'b1;
        ticks(1);
        sw = 1'b0;
        ticks(18);
        check("dbg_in_stagger", rst_periph_n, 1);
        ndm = 1'b1;
        ticks(1);
        check("dbg_periph_low", rst_periph_n, 0);
        check("dbg_cause", cause, 4'b0100);
        ticks(49);
        ndm = 1'b0;
        ticks(15);
        check("dbg_periph_h15", rst_periph_n, 0);
        ticks(1);
        check("dbg_periph_h16", rst_periph_n, 1);
        ticks(8);
        check("dbg_core", rst_core_n, 1);

        // Simultaneous requests, then a restart at hold count 10
        ticks(2);
        sw  = 1'b1;
        ndm = 1'b1;
        ticks(1);
        sw  = 1'b0;
        ndm = 1'b0;
        check("both_cause", cause, 4'b1100);
        check("both_periph", rst_periph_n, 0);
        ticks(10);
        sw = 1'b1;
        ticks(1);
        sw = 1'b0;
        check("restart_cause", cause, 4'b1000);
        ticks(5);
        check("restart_old_deadline", rst_periph_n, 0);
        ticks(10);
        check("restart_h15", rst_periph_n, 0);
        ticks(1);
        check("restart_h16", rst_periph_n, 1);
        ticks(8);
        check("restart_core", rst_core_n, 1);

        // Asynchronous reset at stagger count 3
        ticks(2);
        sw = 1'b1;
        ticks(1);
        sw = 1'b0;
        ticks(19);
        check("async_pre_periph", rst_periph_n, 1);
        check("async_pre_core", rst_core_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_periph", rst_periph_n, 0);
        check("async_core", rst_core_n, 0);
        check("async_cause", cause, 4'b0001);
        check("async_busy", busy, 1);
        ticks(2);
        rst_n = 1'b1;
        ticks(15);
        check("async_rel_h15", rst_periph_n, 0);
        ticks(1);
        check("async_rel_h16", rst_periph_n, 1);
        ticks(7);
        check("async_rel_s7", rst_core_n, 0);
        ticks(1);
        check("async_rel_s8", rst_core_n, 1);
        check("async_rel_busy", busy, 0);
        check("async_rel_cause", cause, 4'b0001);

        ticks(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
